alu_result_arbiter: RTL and testbench
=====================================

Name: alu_result_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 8-input 64-bit ALU result multiplexer. It chooses one of eight functional-unit requesters and drives the mux select. It registers the selected mux output into a result holding register and presents that result downstream with a valid/ready handshake. It sits between the functional-unit outputs and the ALU result/writeback stage.

Parameters:
W, 64, datapath width of mux output and result register.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req  input  8  per-unit result request; unit i holds req[i] and its mux input stable until ack[i].
ack  output  8  one-hot, one-cycle pulse; result of unit i captured.
sel  output  3  registered select driven to the 8-input result mux.
mux_out  input  W  output of the result mux.
res_data  output  W  registered result.
res_src  output  3  index of the unit that produced res_data.
res_valid  output  1  res_data/res_src valid.
res_ready  input  1  downstream accepts the result when res_valid && res_ready.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at an edge, from any state, mid-transfer included): state=IDLE; sel=0; ack=0; res_data=0; res_src=0; res_valid=0; busy=0; ptr=0. Pending results are dropped, and requesters re-arbitrate.
- ptr (3 bits) is the round-robin start index. The search order is ptr, ptr+1, ..., wrapping 7->0. The first set req bit wins.
- States: IDLE, SEL, HOLD.
- IDLE:
  - If req != 0: register the winner g into sel, go to SEL.
  - Else stay; sel holds its last value.
- SEL (sel=g stable for this whole cycle):
  - If req[g]=1: res_data<=mux_out, res_src<=g, ack[g]=1 this cycle (combinational from state/req), ptr<=g+1 mod 8, go to HOLD.
  - If req[g]=0 (requester withdrew): no capture, no ack, ptr unchanged, go to IDLE.
- HOLD:
  - res_valid=1; res_data and res_src stay stable until the handshake.
  - If res_ready=1 and req != 0: arbitrate from the updated ptr, register the new winner into sel, go to SEL. res_valid drops next cycle.
  - If res_ready=1 and req=0: go to IDLE.
  - If res_ready=0: stay.
- Latency: req asserted in IDLE at cycle t gives sel valid at t+1, ack at t+1, and res_valid at t+2. Sustained throughput is one result per 2 cycles.
- Simultaneous requests: exactly one ack per capture, following round-robin order. The unit just served has lowest priority next.
- A new req from the unit currently in HOLD is legal and arbitrates normally.
- ack is never asserted outside SEL. ack is never multi-hot.
- busy = (state != IDLE).
- Width rules: ptr and sel increment modulo 8. res_data is W bits, captured unmodified.

Test Plan:
- Reset: drive rst=1 for 2 cycles with req=8'hFF -> sel=0, ack=0, res_valid=0, res_data=0, busy=0. After release with req=8'h00 -> remains IDLE.
- Single request: req=8'b0000_0100, mux_out=64'hDEAD_BEEF_0000_0002 while sel=2, res_ready=1 -> sel=2 at t+1, ack=8'h04 at t+1, res_valid=1 with res_data=64'hDEAD_BEEF_0000_0002 and res_src=2 at t+2.
- Round-robin with all requesting: req=8'hFF held constant, res_ready=1, deassert req[i] after its ack -> grant order 0,1,2,...,7. Start over with ptr=5 (after serving unit 4) and req=8'h21 -> unit 5 first, then 0 (wrap).
- Backpressure: res_ready=0 for 5 cycles in HOLD with another req pending -> res_valid stays 1, res_data stable, no ack. Raise res_ready -> next winner's sel appears the following cycle.
- Withdrawal: req[3] pulsed 1 cycle only in IDLE -> SEL with sel=3, no ack, back to IDLE, ptr unchanged, res_valid stays 0.
- Reset mid-transfer: rst in SEL and in HOLD -> next cycle everything at reset values, ack=0. Re-arbitration starts at unit 0.

Source files
------------

// File: rtl/alu_result_arbiter.sv
// Round-robin arbiter/sequencer for the shared 8-input ALU result mux.
// Grants one requester, captures the mux output and presents it downstream with valid/ready.
module alu_result_arbiter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   req,
  output logic [7:0]   ack,
  output logic [2:0]   sel,
  input  logic [W-1:0] mux_out,
  output logic [W-1:0] res_data,
  output logic [2:0]   res_src,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         busy
);

  localparam int N = 8;

  typedef enum logic [1:0] {IDLE, SEL, HOLD} state_t;

  state_t       state, state_nxt;
  logic [2:0]   ptr;
  logic [2:0]   win;
  logic [2:0]   off;
  logic [15:0]  dbl;
  logic [7:0]   rot;
  logic         has_req;
  logic         sel_ld;
  logic         cap;

  assign has_req = |req;

  // Rotate so that bit 0 is the ptr position; the lowest set bit is the winner.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[7:0];
    off = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) off = 3'(k);
    end
    win = ptr + off;
  end

  always_comb begin
    state_nxt = state;
    sel_ld    = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (has_req) begin
          sel_ld    = 1'b1;
          state_nxt = SEL;
        end
      end
      SEL: begin
        // A requester that dropped its request before capture simply loses the slot.
        if (req[sel]) begin
          cap       = 1'b1;
          state_nxt = HOLD;
        end else begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (res_ready) begin
          if (has_req) begin
            sel_ld    = 1'b1;
            state_nxt = SEL;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_ack
    assign ack[i] = cap && (sel == 3'(i));
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      ptr      <= '0;
      res_data <= '0;
      res_src  <= '0;
    end else begin
      state <= state_nxt;
      if (sel_ld) sel <= win;
      if (cap) begin
        res_data <= mux_out;
        res_src  <= sel;
        ptr      <= sel + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_arbiter.sv
// Bench for alu_result_arbiter: directed vector table, hand sequences, and
// randomized traffic against a grant/hold reference model.
module tb_alu_result_arbiter;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic [7:0]   req;
  logic [7:0]   ack;
  logic [2:0]   sel;
  logic [W-1:0] mux_out;
  logic [W-1:0] res_data;
  logic [2:0]   res_src;
  logic         res_valid;
  logic         res_ready;
  logic         busy;

  logic [W-1:0] lane_data [8];

  int n_cmp;
  int n_bad;

  assign mux_out = lane_data[sel];

  alu_result_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .sel(sel), .mux_out(mux_out),
    .res_data(res_data), .res_src(res_src), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [7:0]   req;
    logic         rdy;
    logic [7:0]   ack;
    logic [2:0]   sel;
    logic         vld;
    logic         busy;
    logic [2:0]   src;
    logic [63:0]  data;
  } vec_t;

  vec_t tv [22];

  function automatic logic [63:0] dd(int i);
    return 64'hDEAD_BEEF_0000_0000 + 64'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a pending grant and a held result, plus the rotating start index.
  logic         m_pend, m_hold;
  int           m_sel, m_ptr, m_src;
  logic [63:0]  m_data;

  function automatic int pick(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return 0;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_pend = 0; m_hold = 0; m_sel = 0; m_ptr = 0; m_src = 0; m_data = '0;
    end else if (m_pend) begin
      if (req[m_sel]) begin
        m_data = lane_data[m_sel];
        m_src  = m_sel;
        m_ptr  = (m_sel + 1) % 8;
        m_hold = 1;
      end
      m_pend = 0;
    end else if (m_hold) begin
      if (res_ready) begin
        m_hold = 0;
        if (req != 0) begin
          m_sel  = pick(req, m_ptr);
          m_pend = 1;
        end
      end
    end else if (req != 0) begin
      m_sel  = pick(req, m_ptr);
      m_pend = 1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"},   64'(sel), 64'd0);
    chk({tag, "_ack"},   64'(ack), 64'd0);
    chk({tag, "_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_data"},  res_data, 64'd0);
    chk({tag, "_src"},   64'(res_src), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 8; i++) lane_data[i] = dd(i);
    m_pend = 0; m_hold = 0; m_sel = 0; m_ptr = 0; m_src = 0; m_data = '0;

    //            rst   req    rdy   ack    sel   vld   busy  src   data
    tv[0]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0, 64'd0};
    tv[1]  = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0, 64'd0};
    tv[2]  = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0, 64'd0};
    tv[3]  = '{1'b0, 8'h04, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0, 64'd0};
    tv[4]  = '{1'b0, 8'h04, 1'b1, 8'h04, 3'd2, 1'b0, 1'b1, 3'd0, 64'd0};
    tv[5]  = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd2, 1'b1, 1'b1, 3'd2, dd(2)};
    tv[6]  = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0, 3'd2, dd(2)};
    tv[7]  = '{1'b0, 8'h08, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0, 3'd2, dd(2)};
    tv[8]  = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b1, 3'd2, dd(2)};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 3'd2, dd(2)};
    tv[10] = '{1'b0, 8'h18, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 3'd2, dd(2)};
    tv[11] = '{1'b0, 8'h18, 1'b1, 8'h08, 3'd3, 1'b0, 1'b1, 3'd2, dd(2)};
    tv[12] = '{1'b0, 8'h10, 1'b1, 8'h00, 3'd3, 1'b1, 1'b1, 3'd3, dd(3)};
    tv[13] = '{1'b0, 8'h10, 1'b1, 8'h10, 3'd4, 1'b0, 1'b1, 3'd3, dd(3)};
    tv[14] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd4, 1'b1, 1'b1, 3'd4, dd(4)};
    tv[15] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, 3'd4, dd(4)};
    tv[16] = '{1'b0, 8'h21, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, 3'd4, dd(4)};
    tv[17] = '{1'b0, 8'h21, 1'b1, 8'h20, 3'd5, 1'b0, 1'b1, 3'd4, dd(4)};
    tv[18] = '{1'b0, 8'h01, 1'b1, 8'h00, 3'd5, 1'b1, 1'b1, 3'd5, dd(5)};
    tv[19] = '{1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b0, 1'b1, 3'd5, dd(5)};
    tv[20] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b1, 1'b1, 3'd0, dd(0)};
    tv[21] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0, dd(0)};

    rst = 1'b1; req = 8'hFF; res_ready = 1'b1;
    cyc();

    for (int r = 0; r < 22; r++) begin
      rst = tv[r].rst; req = tv[r].req; res_ready = tv[r].rdy;
      #1;
      chk($sformatf("tv%0d_ack", r),   64'(ack),       64'(tv[r].ack));
      chk($sformatf("tv%0d_sel", r),   64'(sel),       64'(tv[r].sel));
      chk($sformatf("tv%0d_valid", r), 64'(res_valid), 64'(tv[r].vld));
      chk($sformatf("tv%0d_busy", r),  64'(busy),      64'(tv[r].busy));
      chk($sformatf("tv%0d_src", r),   64'(res_src),   64'(tv[r].src));
      chk($sformatf("tv%0d_data", r),  res_data,       tv[r].data);
      cyc();
    end

    // Round robin over all eight requesters from a fresh reset.
    rst = 1'b1; req = 8'h00; res_ready = 1'b1;
    cyc();
    rst = 1'b0; req = 8'hFF;
    #1;
    chk("rr_idle_busy", 64'(busy), 64'd0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr%0d_sel", i), 64'(sel), 64'(i));
      chk($sformatf("rr%0d_ack", i), 64'(ack), 64'(8'h01 << i));
      cyc();
      req[i] = 1'b0;
      #1;
      chk($sformatf("rr%0d_valid", i), 64'(res_valid), 64'd1);
      chk($sformatf("rr%0d_src", i),   64'(res_src),   64'(i));
      chk($sformatf("rr%0d_data", i),  res_data,       dd(i));
      cyc();
    end
    chk("rr_end_busy", 64'(busy), 64'd0);

    // Backpressure: result held while another request waits.
    req = 8'h06; res_ready = 1'b0;
    cyc();
    chk("bp_sel1", 64'(sel), 64'd1);
    chk("bp_ack1", 64'(ack), 64'h02);
    cyc();
    req = 8'h04;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_hold%0d_valid", k), 64'(res_valid), 64'd1);
      chk($sformatf("bp_hold%0d_data", k),  res_data,       dd(1));
      chk($sformatf("bp_hold%0d_ack", k),   64'(ack),       64'd0);
      chk($sformatf("bp_hold%0d_sel", k),   64'(sel),       64'd1);
      cyc();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_rel_valid", 64'(res_valid), 64'd1);
    cyc();
    chk("bp_next_sel",   64'(sel),       64'd2);
    chk("bp_next_ack",   64'(ack),       64'h04);
    chk("bp_next_valid", 64'(res_valid), 64'd0);
    cyc();
    req = 8'h00;
    cyc();

    // Reset while in SEL: ptr is 3, so a surviving ptr would pick unit 6 over 0.
    req = 8'h41;
    cyc();
    chk("rs_sel_pre", 64'(sel), 64'd6);
    rst = 1'b1;
    cyc();
    chk_reset_vals("rs_sel");
    rst = 1'b0;
    cyc();
    chk("rs_sel_rearb", 64'(sel), 64'd0);
    chk("rs_sel_ack",   64'(ack), 64'h01);
    cyc();
    res_ready = 1'b0;
    #1;
    chk("rs_hold_valid", 64'(res_valid), 64'd1);
    rst = 1'b1;
    cyc();
    chk_reset_vals("rs_hold");
    rst = 1'b0; res_ready = 1'b1;
    cyc();
    chk("rs_hold_rearb", 64'(sel), 64'd0);
    req = 8'h00;
    cyc();
    cyc();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rst = (n == 0) || ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      res_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < 8; i++) lane_data[i] = {$urandom, $urandom};
      #1;
      if (n != 0) begin
        chk("rnd_sel",   64'(sel),       64'(m_sel));
        chk("rnd_ack",   64'(ack),       (m_pend && req[m_sel]) ? 64'(8'h01 << m_sel) : 64'd0);
        chk("rnd_valid", 64'(res_valid), 64'(m_hold));
        chk("rnd_busy",  64'(busy),      64'(m_pend | m_hold));
        chk("rnd_data",  res_data,       m_data);
        chk("rnd_src",   64'(res_src),   64'(m_src));
      end
      @(posedge clk);
      model_step();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
